// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM.
// It sequences each instruction through fetch, decode, execute, memory and
// writeback, drives the datapath selects and strobes, flags illegal opcodes,
// and counts retired instructions.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int CNT_WIDTH   = 32,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic                   i_or_d,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   branch_eq,
  output logic                   branch_ne,
  output logic [1:0]             pc_source,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   shamt_selector,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   illegal_instr,
  output logic [CNT_WIDTH-1:0]   retired_count
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADDI = 3'b100;
  localparam logic [2:0] ALU_ORI  = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;
  localparam logic [2:0] ALU_R    = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR,
    S_MEM_RD, S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_JAL, S_ILLEGAL
  } state_e;

  state_e                 state_q, state_d;
  logic                   retire_d;
  logic                   fetch_q;
  logic                   mem_req_q, mem_write_q, i_or_d_q, pc_write_q;
  logic                   branch_eq_q, branch_ne_q, reg_write_q;
  logic                   alu_src_a_q, shamt_q, illegal_q;
  logic [1:0]             pc_source_q, reg_dst_q, mem_to_reg_q, alu_src_b_q;
  logic [ALUOP_WIDTH-1:0] alu_op_q;
  logic [CNT_WIDTH-1:0]   count_q;

  // Next-state selection; memory states only advance while a request is
  // actually presented, so mem_ready is ignored in the idle cycle after reset.
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_req_q && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          6'h00:               state_d = (funct == 6'h08) ? S_JR : S_EXEC_R;
          6'h08, 6'h0d, 6'h0f: state_d = S_EXEC_I;
          6'h23, 6'h2b:        state_d = S_MEM_ADDR;
          6'h04, 6'h05:        state_d = S_BRANCH;
          6'h02:               state_d = S_JUMP;
          6'h03:               state_d = ENABLE_JAL ? S_JAL : S_ILLEGAL;
          default:             state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (op == 6'h2b) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_req_q && mem_ready) state_d = S_LW_WB;
      S_MEM_WR: begin
        if (mem_req_q && mem_ready) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
      S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP, S_JR, S_JAL: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // State register plus registered Moore outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      fetch_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      branch_eq_q  <= 1'b0;
      branch_ne_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      shamt_q      <= 1'b0;
      pc_source_q  <= 2'd0;
      reg_dst_q    <= 2'd0;
      mem_to_reg_q <= 2'd0;
      alu_src_b_q  <= 2'd0;
      alu_op_q     <= '0;
      illegal_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      branch_eq_q  <= 1'b0;
      branch_ne_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      shamt_q      <= 1'b0;
      pc_source_q  <= 2'd0;
      reg_dst_q    <= 2'd0;
      mem_to_reg_q <= 2'd0;
      alu_src_b_q  <= 2'd0;
      alu_op_q     <= ALUOP_WIDTH'(ALU_ADD);
      if (retire_d) count_q <= count_q + CNT_WIDTH'(1);
      case (state_d)
        S_FETCH: begin
          fetch_q     <= 1'b1;
          mem_req_q   <= 1'b1;
          alu_src_b_q <= 2'd1;
        end
        S_DECODE:   alu_src_b_q <= 2'd3;
        S_EXEC_R: begin
          alu_src_a_q <= 1'b1;
          alu_op_q    <= ALUOP_WIDTH'(ALU_R);
          shamt_q     <= (funct == 6'h00) || (funct == 6'h02);
        end
        S_R_WB: begin
          reg_dst_q   <= 2'd1;
          reg_write_q <= 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= 2'd2;
          case (op)
            6'h0d:   alu_op_q <= ALUOP_WIDTH'(ALU_ORI);
            6'h0f:   alu_op_q <= ALUOP_WIDTH'(ALU_LUI);
            default: alu_op_q <= ALUOP_WIDTH'(ALU_ADDI);
          endcase
        end
        S_I_WB:     reg_write_q <= 1'b1;
        S_MEM_ADDR: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= 2'd2;
        end
        S_MEM_RD: begin
          mem_req_q <= 1'b1;
          i_or_d_q  <= 1'b1;
        end
        S_LW_WB: begin
          mem_to_reg_q <= 2'd1;
          reg_write_q  <= 1'b1;
        end
        S_MEM_WR: begin
          mem_req_q   <= 1'b1;
          mem_write_q <= 1'b1;
          i_or_d_q    <= 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_q <= 1'b1;
          alu_op_q    <= ALUOP_WIDTH'(ALU_SUB);
          pc_source_q <= 2'd1;
          branch_eq_q <= (op == 6'h04);
          branch_ne_q <= (op == 6'h05);
        end
        S_JUMP: begin
          pc_write_q  <= 1'b1;
          pc_source_q <= 2'd2;
        end
        S_JR: begin
          pc_write_q  <= 1'b1;
          pc_source_q <= 2'd3;
        end
        S_JAL: begin
          reg_dst_q    <= 2'd2;
          mem_to_reg_q <= 2'd2;
          reg_write_q  <= 1'b1;
          pc_write_q   <= 1'b1;
          pc_source_q  <= 2'd2;
        end
        S_ILLEGAL:  illegal_q <= 1'b1;
        default:    fetch_q <= 1'b0;
      endcase
    end
  end

  // The IR and PC+4 loads must land in the same cycle the fetch completes,
  // so they qualify the registered fetch flag with mem_ready directly.
  always_comb begin
    ir_write = fetch_q & mem_ready;
    pc_write = pc_write_q | (fetch_q & mem_ready);
  end

  assign mem_req        = mem_req_q;
  assign mem_write      = mem_write_q;
  assign i_or_d         = i_or_d_q;
  assign branch_eq      = branch_eq_q;
  assign branch_ne      = branch_ne_q;
  assign pc_source      = pc_source_q;
  assign reg_dst        = reg_dst_q;
  assign mem_to_reg     = mem_to_reg_q;
  assign reg_write      = reg_write_q;
  assign alu_src_a      = alu_src_a_q;
  assign alu_src_b      = alu_src_b_q;
  assign shamt_selector = shamt_q;
  assign alu_op         = alu_op_q;
  assign illegal_instr  = illegal_q;
  assign retired_count  = count_q;

endmodule
